// File: rtl/multi_digit_score_display.sv
// Binary score to multi-digit 7-segment driver: serial double-dabble conversion,
// overflow indication, leading-zero blanking and whole-display blink.
//
// state     | meaning
// S_IDLE    | waiting for i_Load; display register holds last result
// S_CONVERT | one double-dabble step per cycle until the counter hits 0
module multi_digit_score_display #(
   parameter int NUM_DIGITS  = 2,
   parameter int SCORE_WIDTH = 7,
   parameter int BLINK_DIV   = 12_500_000
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic [SCORE_WIDTH-1:0]  i_Score,
   input  logic                    i_Load,
   input  logic                    i_Blank_Zeros,
   input  logic                    i_Blink_En,
   output logic                    o_Busy,
   output logic [7*NUM_DIGITS-1:0] o_Segments
);

   // Decimal digits of the largest score, plus one guard nibble.
   function automatic int dec_digits(input int w);
      int v;
      int n;
      v = (1 << w) - 1;
      n = 0;
      while (v > 0) begin
         n++;
         v = v / 10;
      end
      return n;
   endfunction

   localparam int NIB     = dec_digits(SCORE_WIDTH) + 1;
   localparam int MAX_VAL = 10**NUM_DIGITS - 1;
   localparam int CW      = $clog2(SCORE_WIDTH + 1);
   localparam int BW      = $clog2(BLINK_DIV);

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h7E;
         4'd1:    return 7'h30;
         4'd2:    return 7'h6D;
         4'd3:    return 7'h79;
         4'd4:    return 7'h33;
         4'd5:    return 7'h5B;
         4'd6:    return 7'h5F;
         4'd7:    return 7'h70;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h7B;
         default: return 7'h00;
      endcase
   endfunction

   typedef enum logic {S_IDLE, S_CONVERT} state_t;

   state_t                     state;
   logic [CW-1:0]              cnt;
   logic [SCORE_WIDTH-1:0]     sr;
   logic [4*NIB-1:0]           bcd;
   logic [4*NIB-1:0]           bcd_adj;
   logic [4*(NIB+NUM_DIGITS)-1:0] bcd_ext;
   logic                       ovf_pend;
   logic [4*NUM_DIGITS-1:0]    disp;
   logic                       disp_ovf;
   logic [BW-1:0]              blink_cnt;
   logic                       phase_on;
   logic [7*NUM_DIGITS-1:0]    seg_next;
   logic [3:0]                 nib;
   logic                       lead;
   logic                       blank;
   logic [31:0]                score_wide;

   assign score_wide = 32'(i_Score);
   assign bcd_ext    = {{(4*NUM_DIGITS){1'b0}}, bcd};

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NIB; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         o_Busy   <= 1'b0;
         sr       <= '0;
         bcd      <= '0;
         ovf_pend <= 1'b0;
         disp     <= '0;
         disp_ovf <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_Load) begin
                  sr       <= i_Score;
                  bcd      <= '0;
                  cnt      <= CW'(SCORE_WIDTH);
                  ovf_pend <= (score_wide > 32'(MAX_VAL));
                  o_Busy   <= 1'b1;
                  state    <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               if (cnt == '0) begin
                  disp     <= bcd_ext[4*NUM_DIGITS-1:0];
                  disp_ovf <= ovf_pend;
                  o_Busy   <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  {bcd, sr} <= {bcd_adj, sr} << 1;
                  cnt       <= cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         blink_cnt <= '0;
         phase_on  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase_on  <= ~phase_on;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Walk from the most significant digit; blanking stops at the first nonzero digit.
   always_comb begin
      seg_next = '1;
      nib      = '0;
      lead     = 1'b1;
      blank    = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         nib   = disp[4*k +: 4];
         blank = i_Blank_Zeros && lead && (k != 0) && (nib == 4'd0);
         if (nib != 4'd0)
            lead = 1'b0;
         if (disp_ovf)
            seg_next[7*k +: 7] = ~7'h47;
         else if (blank)
            seg_next[7*k +: 7] = 7'h7F;
         else
            seg_next[7*k +: 7] = ~seg_enc(nib);
      end
      if (i_Blink_En && !phase_on)
         seg_next = '1;
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst)
         o_Segments <= '1;
      else
         o_Segments <= seg_next;
   end

endmodule

// File: tb/tb_multi_digit_score_display.sv
// Directed bench for multi_digit_score_display (defaults except BLINK_DIV=4).
module tb_multi_digit_score_display;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b1;
   logic [6:0]  i_Score = '0;
   logic        i_Load = 1'b0;
   logic        i_Blank_Zeros = 1'b0;
   logic        i_Blink_En = 1'b0;
   logic        o_Busy;
   logic [13:0] o_Segments;

   int tests  = 0;
   int failed = 0;
   int edges  = 0;
   int n;

   multi_digit_score_display #(.NUM_DIGITS(2), .SCORE_WIDTH(7), .BLINK_DIV(4)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Score(i_Score), .i_Load(i_Load),
      .i_Blank_Zeros(i_Blank_Zeros), .i_Blink_En(i_Blink_En),
      .o_Busy(o_Busy), .o_Segments(o_Segments)
   );

   always #5 i_Clk = ~i_Clk;

   // Edges since reset release: the blink phase after edge e is off when (e/4) is odd.
   always @(posedge i_Clk or posedge i_Rst)
      if (i_Rst) edges <= 0;
      else       edges <= edges + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_Clk);
      #1;
   endtask

   // Count busy samples starting with n0 already seen, expect SCORE_WIDTH+1, then wait for the output stage.
   task automatic finish_conv(input int n0, input string tag);
      int c;
      c = n0;
      while (o_Busy && c < 40) begin
         step();
         if (o_Busy) c++;
      end
      chk(tag, 32'(c), 32'd8);
      step();
   endtask

   task automatic do_load(input logic [6:0] val, input string tag);
      i_Score = val;
      i_Load  = 1'b1;
      step();
      i_Load  = 1'b0;
      finish_conv(o_Busy ? 1 : 0, tag);
   endtask

   initial begin
      repeat (2) @(posedge i_Clk);
      #1;
      chk("rst_seg", 32'(o_Segments), 32'h3FFF);
      chk("rst_busy", 32'(o_Busy), 32'd0);
      #2 i_Rst = 1'b0;
      step();
      chk("post_rst_zero", 32'(o_Segments), 32'({7'h01, 7'h01}));
      i_Blank_Zeros = 1'b1;
      step();
      chk("post_rst_blank", 32'(o_Segments), 32'({7'h7F, 7'h01}));
      i_Blank_Zeros = 1'b0;

      do_load(7'd42, "busy_42");
      chk("seg_42", 32'(o_Segments), 32'({7'h4C, 7'h12}));
      repeat (5) step();
      chk("hold_42", 32'(o_Segments), 32'({7'h4C, 7'h12}));

      i_Blank_Zeros = 1'b1;
      do_load(7'd5, "busy_5");
      chk("seg_5_blank", 32'(o_Segments), 32'({7'h7F, 7'h24}));
      i_Blank_Zeros = 1'b0;
      step();
      chk("seg_5_noblank", 32'(o_Segments), 32'({7'h01, 7'h24}));

      do_load(7'd100, "busy_100");
      chk("seg_100", 32'(o_Segments), 32'({7'h38, 7'h38}));
      i_Blank_Zeros = 1'b1;
      step();
      chk("seg_100_blank", 32'(o_Segments), 32'({7'h38, 7'h38}));
      i_Blank_Zeros = 1'b0;

      do_load(7'd99, "busy_99");
      chk("seg_99", 32'(o_Segments), 32'({7'h04, 7'h04}));

      i_Blank_Zeros = 1'b1;
      do_load(7'd10, "busy_10");
      chk("seg_10_blank", 32'(o_Segments), 32'({7'h4F, 7'h01}));
      i_Blank_Zeros = 1'b0;

      do_load(7'd127, "busy_127");
      chk("seg_127_ovf", 32'(o_Segments), 32'({7'h38, 7'h38}));

      // Second strobe three cycles into a conversion must be dropped.
      i_Score = 7'd42;
      i_Load  = 1'b1;
      step();
      i_Load  = 1'b0;
      step();
      step();
      i_Score = 7'd17;
      i_Load  = 1'b1;
      step();
      i_Load  = 1'b0;
      finish_conv(4, "busy_ignored");
      chk("seg_ignored", 32'(o_Segments), 32'({7'h4C, 7'h12}));
      repeat (12) step();
      chk("no_queue", 32'(o_Segments), 32'({7'h4C, 7'h12}));
      chk("no_queue_busy", 32'(o_Busy), 32'd0);

      i_Blink_En = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("blink", 32'(o_Segments),
             ((((edges - 1) / 4) % 2) != 0) ? 32'h3FFF : 32'({7'h4C, 7'h12}));
      end
      i_Blink_En = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("blink_off", 32'(o_Segments), 32'({7'h4C, 7'h12}));
      end

      // Reset during the 4th conversion cycle of 42.
      i_Score = 7'd42;
      i_Load  = 1'b1;
      step();
      i_Load  = 1'b0;
      repeat (3) step();
      i_Rst = 1'b1;
      #1;
      chk("midrst_seg", 32'(o_Segments), 32'h3FFF);
      chk("midrst_busy", 32'(o_Busy), 32'd0);
      i_Blank_Zeros = 1'b1;
      i_Score = 7'd7;
      i_Load  = 1'b1;
      #2 i_Rst = 1'b0;
      step();
      i_Load = 1'b0;
      chk("rel_seg", 32'(o_Segments), 32'({7'h7F, 7'h01}));
      chk("first_edge_load", 32'(o_Busy), 32'd1);
      finish_conv(1, "busy_7");
      chk("seg_7_blank", 32'(o_Segments), 32'({7'h7F, 7'h0F}));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
